// File: rtl/multiport_memory.sv
// Multi-port synchronous memory: concurrent registered reads on every port, one
// arbitrated write per cycle, and a power-on clear sequencer driven by reset.
module multiport_memory #(
  parameter int ADDR_SIZE = 8,
  parameter int WIDTH     = 16,
  parameter int NPORTS    = 2,
  parameter int RR        = 1,
  parameter int WR_FWD    = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NPORTS-1:0]           req,
  input  logic [NPORTS-1:0]           we,
  input  logic [NPORTS*ADDR_SIZE-1:0] address,
  input  logic [NPORTS*WIDTH-1:0]     data,
  output logic [NPORTS-1:0]           ready,
  output logic [NPORTS*WIDTH-1:0]     out,
  output logic [NPORTS-1:0]           rvalid,
  output logic                        busy
);

  localparam int DEPTH = 1 << ADDR_SIZE;
  localparam int PW    = (NPORTS > 1) ? $clog2(NPORTS) : 1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  state_t                     state_r;
  state_t                     state_s;
  logic [ADDR_SIZE-1:0]       clr_cnt_r;
  logic [PW-1:0]              ptr_r;
  logic [WIDTH-1:0]           mem_r [DEPTH];

  logic                       run_s;
  logic [NPORTS-1:0]          wr_cand_s;
  logic [NPORTS-1:0]          grant_s;
  logic [PW-1:0]              gidx_s;
  logic [PW-1:0]              cand_idx_s;
  logic                       gvalid_s;
  logic                       wr_en_s;
  logic [ADDR_SIZE-1:0]       wr_addr_s;
  logic [WIDTH-1:0]           wr_data_s;
  logic [NPORTS*WIDTH-1:0]    rd_data_s;

  function automatic logic [PW-1:0] rr_index(input logic [PW-1:0] base, input int offset);
    int v;
    v = (int'(base) + offset) % NPORTS;
    return PW'(v);
  endfunction

  assign run_s     = (state_r == ST_RUN);
  assign wr_cand_s = run_s ? (req & we) : {NPORTS{1'b0}};

  // Write arbiter: scan candidates from the priority base, first hit wins.
  always_comb begin
    gvalid_s   = 1'b0;
    gidx_s     = {PW{1'b0}};
    cand_idx_s = {PW{1'b0}};
    grant_s    = {NPORTS{1'b0}};
    for (int i = 0; i < NPORTS; i++) begin
      if (RR != 0) begin
        cand_idx_s = rr_index(ptr_r, i + 1);
      end else begin
        cand_idx_s = rr_index({PW{1'b0}}, i);
      end
      if (!gvalid_s && wr_cand_s[cand_idx_s]) begin
        gvalid_s = 1'b1;
        gidx_s   = cand_idx_s;
      end else begin
        gvalid_s = gvalid_s;
      end
    end
    grant_s[gidx_s] = gvalid_s;
  end

  // Accept handshake: reads always, writes only for the granted port.
  always_comb begin
    ready = {NPORTS{1'b0}};
    if (run_s) begin
      ready = (req & ~we) | grant_s;
    end else begin
      ready = {NPORTS{1'b0}};
    end
  end

  // Single array write port shared by the clear sequencer and the arbiter.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = {ADDR_SIZE{1'b0}};
    wr_data_s = {WIDTH{1'b0}};
    if (state_r == ST_CLEAR) begin
      wr_en_s   = rst_n;
      wr_addr_s = clr_cnt_r;
      wr_data_s = {WIDTH{1'b0}};
    end else begin
      wr_en_s   = gvalid_s & rst_n;
      wr_addr_s = address[gidx_s*ADDR_SIZE +: ADDR_SIZE];
      wr_data_s = data[gidx_s*WIDTH +: WIDTH];
    end
  end

  // Per-port read data, optionally bypassing the same-cycle write.
  always_comb begin
    rd_data_s = {(NPORTS*WIDTH){1'b0}};
    for (int p = 0; p < NPORTS; p++) begin
      if ((WR_FWD != 0) && wr_en_s && (wr_addr_s == address[p*ADDR_SIZE +: ADDR_SIZE])) begin
        rd_data_s[p*WIDTH +: WIDTH] = wr_data_s;
      end else begin
        rd_data_s[p*WIDTH +: WIDTH] = mem_r[address[p*ADDR_SIZE +: ADDR_SIZE]];
      end
    end
  end

  // Next state: leave CLEAR once the last location is being written.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_CLEAR: begin
        if (clr_cnt_r == {ADDR_SIZE{1'b1}}) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_CLEAR;
        end
      end
      ST_RUN:  state_s = ST_RUN;
      default: state_s = ST_CLEAR;
    endcase
  end

  // Control registers: state, clear counter, round-robin pointer, busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_CLEAR;
      clr_cnt_r <= {ADDR_SIZE{1'b0}};
      ptr_r     <= {PW{1'b0}};
      busy      <= 1'b1;
    end else begin
      state_r <= state_s;
      busy    <= (state_s == ST_CLEAR);
      if (state_r == ST_CLEAR) begin
        clr_cnt_r <= clr_cnt_r + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
      end
      if (gvalid_s) begin
        ptr_r <= gidx_s;
      end
    end
  end

  // Storage array; deliberately not reset, the clear sequencer zeroes it.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wr_addr_s] <= wr_data_s;
    end
  end

  // Registered read returns; out holds its value when no read is accepted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out    <= {(NPORTS*WIDTH){1'b0}};
      rvalid <= {NPORTS{1'b0}};
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (run_s && req[p] && !we[p]) begin
          rvalid[p]           <= 1'b1;
          out[p*WIDTH +: WIDTH] <= rd_data_s[p*WIDTH +: WIDTH];
        end else begin
          rvalid[p] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_multiport_memory.sv
// Scoreboard bench: dut_a (4-bit address, round-robin, forwarding) and dut_b
// (8-bit address, fixed priority, old-data) share stimulus but have separate req.
module tb_multiport_memory;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_a, req_b, we;
  logic [15:0] address;
  logic [31:0] data;
  logic [7:0]  addr_a;
  logic [1:0]  ready_a, ready_b, rvalid_a, rvalid_b;
  logic [31:0] out_a, out_b;
  logic        busy_a, busy_b;

  int total = 0;
  int bad   = 0;

  logic [15:0] qa0[$], qa1[$], qb0[$], qb1[$];

  always #5 clk = ~clk;

  assign addr_a = {address[11:8], address[3:0]};

  multiport_memory #(.ADDR_SIZE(4), .WIDTH(16), .NPORTS(2), .RR(1), .WR_FWD(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .req(req_a), .we(we), .address(addr_a), .data(data),
    .ready(ready_a), .out(out_a), .rvalid(rvalid_a), .busy(busy_a)
  );

  multiport_memory #(.ADDR_SIZE(8), .WIDTH(16), .NPORTS(2), .RR(0), .WR_FWD(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req(req_b), .we(we), .address(address), .data(data),
    .ready(ready_b), .out(out_b), .rvalid(rvalid_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    total++;
    bad++;
    $display("FAIL %s: got rvalid=1 expected no pending read", name);
  endtask

  // Monitor: every returned read is matched against the oldest expectation.
  always @(negedge clk) begin
    if (rvalid_a[0]) begin
      if (qa0.size() == 0) unexpected("a_port0_rdata");
      else check("a_port0_rdata", 32'(out_a[15:0]), 32'(qa0.pop_front()));
    end
    if (rvalid_a[1]) begin
      if (qa1.size() == 0) unexpected("a_port1_rdata");
      else check("a_port1_rdata", 32'(out_a[31:16]), 32'(qa1.pop_front()));
    end
    if (rvalid_b[0]) begin
      if (qb0.size() == 0) unexpected("b_port0_rdata");
      else check("b_port0_rdata", 32'(out_b[15:0]), 32'(qb0.pop_front()));
    end
    if (rvalid_b[1]) begin
      if (qb1.size() == 0) unexpected("b_port1_rdata");
      else check("b_port1_rdata", 32'(out_b[31:16]), 32'(qb1.pop_front()));
    end
  end

  task automatic push(input logic [15:0] a0, input logic [15:0] a1,
                      input logic [15:0] b0, input logic [15:0] b1, input logic [1:0] m);
    if (m[0]) begin qa0.push_back(a0); qb0.push_back(b0); end
    if (m[1]) begin qa1.push_back(a1); qb1.push_back(b1); end
  endtask

  task automatic cyc(input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] w,
                     input logic [7:0] a0, input logic [7:0] a1,
                     input logic [15:0] d0, input logic [15:0] d1,
                     input logic [1:0] era, input logic [1:0] erb);
    req_a   = ra;
    req_b   = rb;
    we      = w;
    address = {a1, a0};
    data    = {d1, d0};
    @(negedge clk);
    check("ready_a", 32'(ready_a), 32'(era));
    check("ready_b", 32'(ready_b), 32'(erb));
    @(posedge clk);
    #1;
    req_a = 2'b00;
    req_b = 2'b00;
  endtask

  task automatic run_clear();
    int cnt_a = 0;
    int cnt_b = 0;
    int rdy_bad = 0;
    int k = 0;
    rst_n   = 1'b1;
    req_a   = 2'b11;
    req_b   = 2'b11;
    we      = 2'b00;
    address = 16'h0000;
    do begin
      @(negedge clk);
      if (busy_a) begin
        cnt_a++;
        if (ready_a !== 2'b00) rdy_bad++;
      end else begin
        req_a = 2'b00;
      end
      if (busy_b) begin
        cnt_b++;
        if (ready_b !== 2'b00) rdy_bad++;
      end else begin
        req_b = 2'b00;
      end
      k++;
    end while ((busy_a || busy_b) && k < 400);
    check("clear_cycles_a", 32'(cnt_a), 32'd16);
    check("clear_cycles_b", 32'(cnt_b), 32'd256);
    check("clear_ready_low", 32'(rdy_bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic read_all_zero();
    for (int i = 0; i < 128; i++) begin
      push(16'h0000, 16'h0000, 16'h0000, 16'h0000, 2'b11);
      cyc(2'b11, 2'b11, 2'b00, 8'(i), 8'(i + 128), 16'h0000, 16'h0000, 2'b11, 2'b11);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected test completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n   = 1'b0;
    req_a   = 2'b00;
    req_b   = 2'b00;
    we      = 2'b00;
    address = 16'h0000;
    data    = 32'h0000_0000;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {30'd0, busy_a, busy_b}, 32'd3);
    check("reset_rvalid", {28'd0, rvalid_a, rvalid_b}, 32'd0);
    check("reset_out_a", out_a, 32'd0);
    check("reset_out_b", out_b, 32'd0);
    run_clear();
    read_all_zero();

    // Concurrent read of one address after a write.
    cyc(2'b01, 2'b01, 2'b01, 8'h05, 8'h00, 16'hBEEF, 16'h0000, 2'b01, 2'b01);
    push(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 2'b11);
    cyc(2'b11, 2'b11, 2'b00, 8'h05, 8'h05, 16'h0000, 16'h0000, 2'b11, 2'b11);

    // Write contention: a is round-robin (port 1 first), b fixed priority (port 0 first).
    cyc(2'b11, 2'b11, 2'b11, 8'h10, 8'h10, 16'h1111, 16'h2222, 2'b10, 2'b01);
    cyc(2'b01, 2'b10, 2'b11, 8'h10, 8'h10, 16'h1111, 16'h2222, 2'b01, 2'b10);
    push(16'h1111, 16'h1111, 16'h2222, 16'h2222, 2'b11);
    cyc(2'b11, 2'b11, 2'b00, 8'h10, 8'h10, 16'h0000, 16'h0000, 2'b11, 2'b11);

    // Read-during-write: a forwards new data, b returns old data.
    cyc(2'b01, 2'b01, 2'b01, 8'h20, 8'h00, 16'hAAAA, 16'h0000, 2'b01, 2'b01);
    push(16'h0000, 16'h5555, 16'h0000, 16'hAAAA, 2'b10);
    cyc(2'b11, 2'b11, 2'b01, 8'h20, 8'h20, 16'h5555, 16'h0000, 2'b11, 2'b11);
    push(16'h5555, 16'h0000, 16'h5555, 16'h0000, 2'b01);
    cyc(2'b01, 2'b01, 2'b00, 8'h20, 8'h00, 16'h0000, 16'h0000, 2'b01, 2'b01);

    // Idle hold: out keeps 0x1234, pointer of a stays at port 1.
    cyc(2'b10, 2'b10, 2'b10, 8'h00, 8'h33, 16'h0000, 16'h1234, 2'b10, 2'b10);
    push(16'h0000, 16'h1234, 16'h0000, 16'h1234, 2'b10);
    cyc(2'b10, 2'b10, 2'b00, 8'h00, 8'h33, 16'h0000, 16'h0000, 2'b10, 2'b10);
    for (int i = 0; i < 3; i++) begin
      cyc(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0000, 16'h0000, 2'b00, 2'b00);
      check("idle_rvalid", {28'd0, rvalid_a, rvalid_b}, 32'd0);
      check("idle_out_a", 32'(out_a[31:16]), 32'h1234);
      check("idle_out_b", 32'(out_b[31:16]), 32'h1234);
    end
    cyc(2'b11, 2'b11, 2'b11, 8'h44, 8'h44, 16'h0A0A, 16'h0B0B, 2'b01, 2'b01);
    cyc(2'b10, 2'b10, 2'b11, 8'h44, 8'h44, 16'h0A0A, 16'h0B0B, 2'b10, 2'b10);
    push(16'h0B0B, 16'h0B0B, 16'h0B0B, 16'h0B0B, 2'b11);
    cyc(2'b11, 2'b11, 2'b00, 8'h44, 8'h44, 16'h0000, 16'h0000, 2'b11, 2'b11);

    // Mid-operation reset during a read burst.
    push(16'hBEEF, 16'hBEEF, 16'hBEEF, 16'hBEEF, 2'b11);
    cyc(2'b11, 2'b11, 2'b00, 8'h05, 8'h05, 16'h0000, 16'h0000, 2'b11, 2'b11);
    rst_n   = 1'b0;
    req_a   = 2'b11;
    req_b   = 2'b11;
    we      = 2'b00;
    address = 16'h0505;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req_a = 2'b00;
    req_b = 2'b00;
    check("midrst_rvalid", {28'd0, rvalid_a, rvalid_b}, 32'd0);
    check("midrst_out_a", out_a, 32'd0);
    check("midrst_out_b", out_b, 32'd0);
    check("midrst_busy", {30'd0, busy_a, busy_b}, 32'd3);
    run_clear();
    read_all_zero();

    repeat (3) @(posedge clk);
    #1;
    check("pending_a0", 32'(qa0.size()), 32'd0);
    check("pending_a1", 32'(qa1.size()), 32'd0);
    check("pending_b0", 32'(qb0.size()), 32'd0);
    check("pending_b1", 32'(qb1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
